fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the pipelined LC-3b core. It sits directly upstream of the decode-stage instruction register. It owns the PC and drives the instruction-memory read handshake. It presents fetched instructions to decode with a valid/stall handshake, using a one-entry skid buffer so that a response is never lost. A redirect (taken branch, JMP, TRAP) flushes everything in flight, including a read that has already been issued to memory.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- imem_read  out  1  read request; held high until imem_resp.
- imem_address  out  16  byte address of the read; stable while imem_read is high.
- imem_resp  in  1  read complete this cycle.
- imem_rdata  in  16  instruction word; valid when imem_resp=1.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address; bit 0 ignored (forced 0).
- stall  in  1  decode cannot accept this cycle.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst  out  16  instruction word (lc3b_word), feeds the decode IR `in`.
- inst_pc  out  16  byte address of inst.
- inst_pc_plus2  out  16  inst_pc + 2, for PC-relative and link use.

## Operation
- Registers:
  - pc: next fetch address.
  - req_addr: address of the outstanding read.
  - output slot: inst, inst_pc, inst_valid.
  - skid slot: instruction word, its pc, skid_valid.
  - 2-bit state.
- States:
  - IDLE: no read.
  - REQ: imem_read=1, imem_address=req_addr.
  - DRAIN: imem_read=1, old req_addr; the response will be discarded.
- Consume: the output slot empties when inst_valid=1 and stall=0.
- Skid refill: in the same cycle as a consume, a valid skid entry moves into the output slot.
- IDLE to REQ: when the skid slot will be empty next cycle. On that edge req_addr <= pc.
- REQ with imem_resp=1, no redirect:
  - The word and req_addr go to the output slot if it is empty or being consumed this cycle; otherwise they go to the skid slot.
  - pc <= pc+2 (16-bit wrap, 16'hFFFE to 16'h0000).
  - Next state is REQ with req_addr <= pc+2 if the skid slot stays empty; otherwise IDLE.
- Redirect (highest priority, overrides stall and imem_resp):
  - inst_valid <= 0 and skid_valid <= 0.
  - pc <= {redirect_pc[15:1],0}.
  - From IDLE: go to REQ with req_addr <= the new pc.
  - From REQ with imem_resp=1: discard the response, go to REQ at the new address.
  - From REQ with imem_resp=0: go to DRAIN; req_addr is unchanged.
  - From DRAIN: pc is updated and the state stays DRAIN.
- DRAIN: on imem_resp the data is dropped and the block goes to REQ with req_addr <= pc. The outstanding read is never abandoned or re-addressed.
- Stall only blocks consumption. It never changes imem_read or imem_address mid-transaction.
- Output ordering matches fetch order. The skid entry is always older than any later response.

## Timing
- Reset (sync) values:
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC.
  - inst_valid=0, skid_valid=0, imem_read=0.
  - inst=16'h0000, inst_pc=16'h0000, inst_pc_plus2=16'h0002.
- First read: imem_read rises on the first edge after reset deasserts, with address RESET_PC.
- Latency: a response in cycle N gives inst_valid=1 in cycle N+1.
- Throughput: one instruction per cycle with single-cycle memory and no stall.
- Redirect in cycle N:
  - inst_valid=0 in cycle N+1.
  - If no read is stranded, imem_address=target in N+1.
  - Otherwise the target is issued the cycle after the stranded imem_resp.
- Backpressure: a stall held with both slots full stops fetching (IDLE). On the first consume, the skid moves to the output and a new read issues the next cycle.
- Reset mid-read: imem_read drops the next cycle. The stranded response is not tracked; the memory side is reset with the core.
- Outputs are all registered; none are combinational on imem_resp except imem_read (state-derived).

## Test plan
- Reset, then memory answers every cycle with rdata = address ^ 16'h1234 → addresses 0,2,4,...; inst_valid from cycle 2; inst_pc 0,2,4; inst_pc_plus2 = inst_pc+2.
- 3-cycle memory latency, no stall → imem_address is held constant for 3 cycles per read; one instruction every 3 cycles, no duplicates or skips.
- stall=1 for 5 cycles with single-cycle memory → output holds pc 0x0004, skid holds 0x0006, imem_read low; on release, pcs 0x0004, 0x0006, 0x0008 are delivered in order.
- redirect to 16'h3001 while IDLE with both slots full → both slots flushed; next read address is 0x3000; first valid inst_pc is 0x3000.
- redirect to 0x0400 two cycles into a 4-cycle read of 0x0010 → address stays 0x0010 until resp, that data is dropped, then 0x0400 is read; inst_pc 0x0010 never appears.
- pc=0xFFFE fetch, then reset asserted during a later pending read → wrap to 0x0000 observed; after reset all outputs are at their reset values and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read handshake plus decode-side valid/stall.
// Latency: none (wires only).
// Backpressure: stall from decode, imem_resp from memory; fetch is the master of both.
interface fetch_unit_if;
    // instruction memory side
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    // control from later stages
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    // decode side
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] inst_pc_plus2;

    modport master (
        output imem_read, imem_address, inst_valid, inst, inst_pc, inst_pc_plus2,
        input  imem_resp, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_read, imem_address, inst_valid, inst, inst_pc, inst_pc_plus2,
        output imem_resp, imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/fetch_unit.sv
// LC-3b instruction fetch: owns the PC, issues imem reads, feeds decode through an output slot plus one skid entry.
// Latency: imem_resp in cycle N gives inst_valid in N+1; one instruction per cycle with single-cycle memory.
// Backpressure: stall blocks consumption only; with both slots full fetching pauses (IDLE) until decode drains one.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_req_addr;
    logic        r_inst_valid;
    logic [15:0] r_inst;
    logic [15:0] r_inst_pc;
    logic [15:0] r_inst_pc_plus2;
    logic        r_skid_valid;
    logic [15:0] r_skid_inst;
    logic [15:0] r_skid_pc;

    logic        w_consume;
    logic        w_to_out;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_target;

    // decode takes the output slot this cycle
    assign w_consume  = r_inst_valid & ~bus.stall;
    // a response may land in the output slot only if it is free and nothing older waits in the skid
    assign w_to_out   = (~r_inst_valid | w_consume) & ~r_skid_valid;
    assign w_pc_plus2 = r_pc + 16'd2;
    assign w_target   = bus.redirect_pc & 16'hFFFE;

    assign bus.imem_read     = (r_state != S_IDLE);
    assign bus.imem_address  = r_req_addr;
    assign bus.inst_valid    = r_inst_valid;
    assign bus.inst          = r_inst;
    assign bus.inst_pc       = r_inst_pc;
    assign bus.inst_pc_plus2 = r_inst_pc_plus2;

    // PC, read sequencing and the two-slot output queue; redirect beats everything else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_pc            <= RESET_PC;
            r_req_addr      <= RESET_PC;
            r_inst_valid    <= 1'b0;
            r_inst          <= 16'h0000;
            r_inst_pc       <= 16'h0000;
            r_inst_pc_plus2 <= 16'h0002;
            r_skid_valid    <= 1'b0;
            r_skid_inst     <= 16'h0000;
            r_skid_pc       <= 16'h0000;
        end else if (bus.redirect) begin
            r_inst_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_pc         <= w_target;
            if (r_state == S_IDLE || bus.imem_resp) begin
                // nothing left outstanding: start the target read right away
                r_state    <= S_REQ;
                r_req_addr <= w_target;
            end else begin
                // a read is in flight; keep its address and wait it out
                r_state <= S_DRAIN;
            end
        end else begin
            if (w_consume) begin
                if (r_skid_valid) begin
                    r_inst          <= r_skid_inst;
                    r_inst_pc       <= r_skid_pc;
                    r_inst_pc_plus2 <= r_skid_pc + 16'd2;
                    r_skid_valid    <= 1'b0;
                end else begin
                    r_inst_valid <= 1'b0;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (!r_skid_valid || w_consume) begin
                        r_state    <= S_REQ;
                        r_req_addr <= r_pc;
                    end
                end
                S_REQ: begin
                    if (bus.imem_resp) begin
                        r_pc <= w_pc_plus2;
                        if (w_to_out) begin
                            r_inst          <= bus.imem_rdata;
                            r_inst_pc       <= r_req_addr;
                            r_inst_pc_plus2 <= r_req_addr + 16'd2;
                            r_inst_valid    <= 1'b1;
                            r_req_addr      <= w_pc_plus2;
                        end else begin
                            // output busy: park in the skid and stop fetching until it drains
                            r_skid_inst  <= bus.imem_rdata;
                            r_skid_pc    <= r_req_addr;
                            r_skid_valid <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    // stale data is dropped; the redirect target is fetched next
                    if (bus.imem_resp) begin
                        r_state    <= S_REQ;
                        r_req_addr <= r_pc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory answering rdata = address ^ 16'h1234.
// Latency: checks are cycle-exact, sampled 1 time unit after each rising edge.
// Backpressure: stall and redirect are driven from the stimulus sequence.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int lat = 1;
    int cnt = 0;
    bit prev_resp = 1'b0;
    bit seen_0010 = 1'b0;

    // memory model: responds in the lat-th cycle of each read
    always @(negedge clk) begin
        if (reset || !bus.imem_read) begin
            cnt = 0;
            prev_resp = 1'b0;
            bus.imem_resp = 1'b0;
        end else begin
            cnt = prev_resp ? 1 : cnt + 1;
            bus.imem_resp = (cnt >= lat);
            prev_resp = bus.imem_resp;
        end
        bus.imem_rdata = bus.imem_address ^ 16'h1234;
    end

    // watch for the address whose data must be discarded
    always @(negedge clk) begin
        if (bus.inst_valid && bus.inst_pc == 16'h0010) seen_0010 = 1'b1;
    end

    task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // one cycle of expectations; address only meaningful while reading, data only while valid
    task automatic chk_cyc(input string tag, input logic rd, input logic [15:0] addr,
                           input logic vld, input logic [15:0] pc);
        chk_eq({tag, ".rd"}, {15'd0, bus.imem_read}, {15'd0, rd});
        if (rd) chk_eq({tag, ".addr"}, bus.imem_address, addr);
        chk_eq({tag, ".vld"}, {15'd0, bus.inst_valid}, {15'd0, vld});
        if (vld) begin
            chk_eq({tag, ".pc"}, bus.inst_pc, pc);
            chk_eq({tag, ".inst"}, bus.inst, pc ^ 16'h1234);
            chk_eq({tag, ".pc2"}, bus.inst_pc_plus2, pc + 16'd2);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk_eq({tag, ".rd"}, {15'd0, bus.imem_read}, 16'd0);
        chk_eq({tag, ".addr"}, bus.imem_address, 16'h0000);
        chk_eq({tag, ".vld"}, {15'd0, bus.inst_valid}, 16'd0);
        chk_eq({tag, ".inst"}, bus.inst, 16'h0000);
        chk_eq({tag, ".pc"}, bus.inst_pc, 16'h0000);
        chk_eq({tag, ".pc2"}, bus.inst_pc_plus2, 16'h0002);
    endtask

    // leaves the bench in cycle 0: first cycle with reset low, DUT still idle
    task automatic do_reset;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        seen_0010 = 1'b0;
        step;
        step;
        chk_rst("rst");
        reset = 1'b0;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;

        // streaming, stall with both slots full, redirect while idle
        lat = 1;
        do_reset;
        chk_cyc("s0", 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk_rst("s0r");
        step; chk_cyc("s1", 1'b1, 16'h0000, 1'b0, 16'h0000);
        step; chk_cyc("s2", 1'b1, 16'h0002, 1'b1, 16'h0000);
        step; chk_cyc("s3", 1'b1, 16'h0004, 1'b1, 16'h0002);
        step; chk_cyc("s4", 1'b1, 16'h0006, 1'b1, 16'h0004);
        bus.stall = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            step; chk_cyc("stall", 1'b0, 16'h0000, 1'b1, 16'h0004);
        end
        step; bus.stall = 1'b0;
        chk_cyc("s9", 1'b0, 16'h0000, 1'b1, 16'h0004);
        step; chk_cyc("s10", 1'b1, 16'h0008, 1'b1, 16'h0006);
        step; chk_cyc("s11", 1'b1, 16'h000A, 1'b1, 16'h0008);
        bus.stall = 1'b1;
        step; chk_cyc("s12", 1'b0, 16'h0000, 1'b1, 16'h0008);
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h3001;
        step; bus.redirect = 1'b0; bus.stall = 1'b0;
        chk_cyc("r13", 1'b1, 16'h3000, 1'b0, 16'h0000);
        step; chk_cyc("r14", 1'b1, 16'h3002, 1'b1, 16'h3000);
        step; chk_cyc("r15", 1'b1, 16'h3004, 1'b1, 16'h3002);

        // 3-cycle memory: address held three cycles, one instruction per read
        lat = 3;
        do_reset;
        chk_cyc("l0", 1'b0, 16'h0000, 1'b0, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            step; chk_cyc("l1", 1'b1, 16'h0000, 1'b0, 16'h0000);
        end
        step; chk_cyc("l4", 1'b1, 16'h0002, 1'b1, 16'h0000);
        step; chk_cyc("l5", 1'b1, 16'h0002, 1'b0, 16'h0000);
        step; chk_cyc("l6", 1'b1, 16'h0002, 1'b0, 16'h0000);
        step; chk_cyc("l7", 1'b1, 16'h0004, 1'b1, 16'h0002);
        step; step;
        step; chk_cyc("l10", 1'b1, 16'h0006, 1'b1, 16'h0004);

        // redirect during a 4-cycle read of 0x0010: read completes, data dropped
        lat = 4;
        do_reset;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0010;
        step; bus.redirect = 1'b0;
        chk_cyc("d1", 1'b1, 16'h0010, 1'b0, 16'h0000);
        step; chk_cyc("d2", 1'b1, 16'h0010, 1'b0, 16'h0000);
        step; bus.redirect = 1'b1; bus.redirect_pc = 16'h0400;
        chk_cyc("d3", 1'b1, 16'h0010, 1'b0, 16'h0000);
        step; bus.redirect = 1'b0;
        chk_cyc("d4", 1'b1, 16'h0010, 1'b0, 16'h0000);
        for (int i = 5; i <= 8; i++) begin
            step; chk_cyc("d5", 1'b1, 16'h0400, 1'b0, 16'h0000);
        end
        step; chk_cyc("d9", 1'b1, 16'h0402, 1'b1, 16'h0400);
        chk_eq("d.seen10", {15'd0, seen_0010}, 16'd0);

        // PC wrap at 0xFFFE, then reset during a pending read
        lat = 1;
        do_reset;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'hFFFC;
        step; bus.redirect = 1'b0;
        chk_cyc("w1", 1'b1, 16'hFFFC, 1'b0, 16'h0000);
        step; chk_cyc("w2", 1'b1, 16'hFFFE, 1'b1, 16'hFFFC);
        step; chk_cyc("w3", 1'b1, 16'h0000, 1'b1, 16'hFFFE);
        step; chk_cyc("w4", 1'b1, 16'h0002, 1'b1, 16'h0000);
        lat = 3;
        step; chk_cyc("w5", 1'b1, 16'h0002, 1'b0, 16'h0000);
        reset = 1'b1;
        step; reset = 1'b0;
        chk_rst("w6");
        step; chk_cyc("w7", 1'b1, 16'h0000, 1'b0, 16'h0000);
        step; step;
        step; chk_cyc("w10", 1'b1, 16'h0002, 1'b1, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
